// File: rtl/router_port_rx.sv
// Downstream consumer for one router output port: drains the port FIFO, parses
// header/payload/parity, forwards payload to a valid/ready sink and keeps status counters.
module router_port_rx #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter logic [7:0] GAP_MAX = 8'd24
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  input  logic        sink_ready,
  output logic        read_enb,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        pkt_start,
  output logic [5:0]  pkt_len,
  output logic [1:0]  pkt_addr,
  output logic        addr_err,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        pkt_abort,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {StIdle, StPayload, StParity} state_e;

  state_e      state_q, state_d;
  logic        rd_q;
  logic [7:0]  acc_q, acc_d;
  logic [5:0]  rem_q, rem_d;
  logic [7:0]  gap_q, gap_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  addr_q, addr_d;
  logic        start_q, start_d, aerr_q, aerr_d, done_q, done_d, perr_q, perr_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

  logic [7:0]  q_mem [2];
  logic        q_wptr_q, q_rptr_q;
  logic [1:0]  occ_q, occ_d;
  logic        push, pop, abort, err_evt;
  logic [2:0]  occ_sum;

  assign byte_valid = (occ_q != 2'd0);
  assign byte_data  = q_mem[q_rptr_q];
  assign pop        = byte_valid & sink_ready;
  // Reserve queue room for any byte in flight, header and parity included.
  assign occ_sum    = {1'b0, occ_q} + {2'b00, rd_q} - {2'b00, pop};
  assign read_enb   = vld_out & (occ_sum < 3'd2);
  assign abort      = (state_q != StIdle) & ~vld_out & (gap_q == GAP_MAX - 8'd1);

  assign pkt_start  = start_q;
  assign addr_err   = aerr_q;
  assign pkt_done   = done_q;
  assign parity_err = perr_q;
  assign pkt_abort  = abort;
  assign pkt_len    = len_q;
  assign pkt_addr   = addr_q;
  assign pkt_count  = pkt_cnt_q;
  assign err_count  = err_cnt_q;
  assign err_evt    = perr_q | aerr_q | abort;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    gap_d   = vld_out ? 8'd0 : gap_q + 8'd1;
    len_d   = len_q;
    addr_d  = addr_q;
    start_d = 1'b0;
    aerr_d  = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_q) begin
          len_d   = data_out[7:2];
          addr_d  = data_out[1:0];
          acc_d   = data_out;
          rem_d   = data_out[7:2];
          start_d = 1'b1;
          aerr_d  = (data_out[1:0] != PORT_ID);
          state_d = (data_out[7:2] != 6'd0) ? StPayload : StParity;
        end
      end
      StPayload: begin
        if (rd_q) begin
          push  = 1'b1;
          acc_d = acc_q ^ data_out;
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) state_d = StParity;
        end
      end
      StParity: begin
        if (rd_q) begin
          done_d  = 1'b1;
          perr_d  = (data_out != acc_q);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      acc_d   = 8'd0;
      rem_d   = 6'd0;
      push    = 1'b0;
    end
    if (state_d == StIdle) gap_d = 8'd0;
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
    pkt_cnt_d = (done_q && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_cnt_d = (err_evt && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rd_q      <= 1'b0;
      acc_q     <= 8'd0;
      rem_q     <= 6'd0;
      gap_q     <= 8'd0;
      len_q     <= 6'd0;
      addr_q    <= 2'd0;
      start_q   <= 1'b0;
      aerr_q    <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      pkt_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
      q_mem[0]  <= 8'd0;
      q_mem[1]  <= 8'd0;
      q_wptr_q  <= 1'b0;
      q_rptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      rd_q      <= read_enb;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      aerr_q    <= aerr_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      occ_q     <= occ_d;
      if (push) begin
        q_mem[q_wptr_q] <= data_out;
        q_wptr_q        <= ~q_wptr_q;
      end
      if (pop) q_rptr_q <= ~q_rptr_q;
    end
  end

endmodule
